// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared owner encodings and default geometry for the SRAM arbiter
package sram_arbiter_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int ADDR_W_DEF    = 9;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_C    = 2'b01,
    OWN_I    = 2'b10
  } owner_e;

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - combinational winner selection; SRAM_ARB_RR_EN selects round-robin
module sram_arb_pick
  import sram_arbiter_pkg::*;
`ifndef SRAM_ARB_RR_EN
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int BURST_W   = $clog2(MAX_BURST + 1)
)
`endif
(
  input  logic               c_req_i,
  input  logic               i_req_i,
`ifdef SRAM_ARB_RR_EN
  input  owner_e             last_owner_i,
`else
  input  logic [BURST_W-1:0] burst_cnt_i,
`endif
  output logic [1:0]         gnt_o
);

  // gnt_o[0] grants the core, gnt_o[1] grants the loader
  always_comb begin
    gnt_o = 2'b00;
    if (c_req_i && i_req_i) begin
`ifdef SRAM_ARB_RR_EN
      gnt_o = (last_owner_i == OWN_C) ? 2'b10 : 2'b01;
`else
      gnt_o = (burst_cnt_i == BURST_W'(MAX_BURST)) ? 2'b10 : 2'b01;
`endif
    end else if (c_req_i) begin
      gnt_o = 2'b01;
    end else if (i_req_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port SRAM arbiter and access sequencer; SRAM_ARB_RR_EN selects round-robin
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic [ADDR_W-1:0] c_a_i,
  input  logic [DATA_W-1:0] c_d_i,
  output logic              c_gnt_o,
  output logic              c_vld_o,
  output logic [DATA_W-1:0] c_q_o,
  input  logic              i_req_i,
  input  logic              i_we_i,
  input  logic [ADDR_W-1:0] i_a_i,
  input  logic [DATA_W-1:0] i_d_i,
  output logic              i_gnt_o,
  output logic              i_vld_o,
  output logic [DATA_W-1:0] i_q_o,
  output logic              cen_o,
  output logic              wen_o,
  output logic [ADDR_W-1:0] a_o,
  output logic [DATA_W-1:0] d_o,
  input  logic [DATA_W-1:0] q_i,
  output logic              busy_o
);

  logic [1:0]        pick_gnt;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_d;

  logic              cen_q, cen_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] d_q, d_d;
  owner_e            own0_q, own0_d;
  owner_e            own1_q, own2_q;
  logic [DATA_W-1:0] c_q_q, c_q_d;
  logic [DATA_W-1:0] i_q_q, i_q_d;

`ifdef SRAM_ARB_RR_EN
  owner_e last_q, last_d;

  sram_arb_pick u_pick (
    .c_req_i      (c_req_i),
    .i_req_i      (i_req_i),
    .last_owner_i (last_q),
    .gnt_o        (pick_gnt)
  );

  always_comb begin
    last_d = last_q;
    if (gnt[0]) begin
      last_d = OWN_C;
    end else if (gnt[1]) begin
      last_d = OWN_I;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_I;
    end else begin
      last_q <= last_d;
    end
  end
`else
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  logic [BURST_W-1:0] burst_q, burst_d;

  sram_arb_pick #(
    .MAX_BURST (MAX_BURST),
    .BURST_W   (BURST_W)
  ) u_pick (
    .c_req_i     (c_req_i),
    .i_req_i     (i_req_i),
    .burst_cnt_i (burst_q),
    .gnt_o       (pick_gnt)
  );

  // Counts core grants the loader has watched go by; the guard in the picker keeps it <= MAX_BURST
  always_comb begin
    burst_d = burst_q;
    if (!i_req_i || gnt[1]) begin
      burst_d = '0;
    end else if (gnt[0]) begin
      burst_d = burst_q + BURST_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`endif

  assign gnt     = pick_gnt & {2{rst_n}};
  assign any_gnt = |gnt;
  assign sel_we  = gnt[1] ? i_we_i : c_we_i;
  assign sel_a   = gnt[1] ? i_a_i  : c_a_i;
  assign sel_d   = gnt[1] ? i_d_i  : c_d_i;

  always_comb begin
    cen_d  = 1'b1;
    wen_d  = 1'b1;
    a_d    = '0;
    d_d    = '0;
    own0_d = OWN_NONE;
    if (any_gnt) begin
      cen_d = 1'b0;
      wen_d = ~sel_we;
      a_d   = sel_a;
      d_d   = sel_d;
      if (!sel_we) begin
        own0_d = gnt[1] ? OWN_I : OWN_C;
      end
    end
  end

  // SRAM Q is valid while the tag sits in stage 1; capture it only for the tagged port
  always_comb begin
    c_q_d = c_q_q;
    i_q_d = i_q_q;
    if (own1_q == OWN_C) begin
      c_q_d = q_i;
    end
    if (own1_q == OWN_I) begin
      i_q_d = q_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cen_q  <= 1'b1;
      wen_q  <= 1'b1;
      a_q    <= '0;
      d_q    <= '0;
      own0_q <= OWN_NONE;
      own1_q <= OWN_NONE;
      own2_q <= OWN_NONE;
      c_q_q  <= '0;
      i_q_q  <= '0;
    end else begin
      cen_q  <= cen_d;
      wen_q  <= wen_d;
      a_q    <= a_d;
      d_q    <= d_d;
      own0_q <= own0_d;
      own1_q <= own0_q;
      own2_q <= own1_q;
      c_q_q  <= c_q_d;
      i_q_q  <= i_q_d;
    end
  end

  assign c_gnt_o = gnt[0];
  assign i_gnt_o = gnt[1];
  assign cen_o   = cen_q;
  assign wen_o   = wen_q;
  assign a_o     = a_q;
  assign d_o     = d_q;
  assign c_vld_o = (own2_q == OWN_C);
  assign i_vld_o = (own2_q == OWN_I);
  assign c_q_o   = c_q_q;
  assign i_q_o   = i_q_q;
  assign busy_o  = ~cen_q | (own1_q != OWN_NONE) | (own2_q != OWN_NONE);

endmodule
